// File: rtl/flopr_sync.sv
// Parameterized D register with synchronous active-low reset, optionally
// cascaded STAGES deep to form a fixed-latency delay line.

module flopr_sync_stage #(
    parameter int                 WIDTH       = 64,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!reset) data_q <= RESET_VALUE;
        else        data_q <= data_i;
    end

    assign data_o = data_q;
endmodule

module flopr_sync #(
    parameter int                 WIDTH       = 64,
    parameter int                 STAGES      = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("flopr_sync: WIDTH must be >= 1");
        end
        if (STAGES < 1) begin : g_bad_stages
            $error("flopr_sync: STAGES must be >= 1");
        end
    endgenerate

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // Stage 0 takes d; each later stage takes its predecessor, so a reset
    // edge clears every in-flight word at once.
    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            if (i == 0) begin : g_head
                flopr_sync_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
                    .clk   (clk),
                    .reset (reset),
                    .data_i(d),
                    .data_o(stage_q[i])
                );
            end else begin : g_tail
                flopr_sync_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
                    .clk   (clk),
                    .reset (reset),
                    .data_i(stage_q[i-1]),
                    .data_o(stage_q[i])
                );
            end
        end
    endgenerate

    assign q = stage_q[STAGES-1];
endmodule

// File: tb/tb_flopr_sync.sv
// Randomized and directed bench for flopr_sync: 64-bit and 32-bit single
// stage instances plus a 3-stage instance with a non-zero reset value.

module tb_flopr_sync;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] d = '0;
    logic [63:0] q64;
    logic [31:0] q32;
    logic [63:0] qp;

    int total  = 0;
    int passed = 0;

    // Edge history as seen by the DUT: reset and d sampled at every rising edge.
    bit          hist_rst[$];
    logic [63:0] hist_d[$];

    localparam logic [63:0] PRV = 64'hDEAD;

    always #5 clk = ~clk;

    flopr_sync #(.WIDTH(64), .STAGES(1)) u_q64 (.clk(clk), .reset(reset), .d(d), .q(q64));
    flopr_sync #(.WIDTH(32), .STAGES(1)) u_q32 (.clk(clk), .reset(reset), .d(d[31:0]), .q(q32));
    flopr_sync #(.WIDTH(64), .STAGES(3), .RESET_VALUE(PRV)) u_qp (.clk(clk), .reset(reset), .d(d), .q(qp));

    // Output of an S-deep chain after the latest edge: the word sampled S-1
    // edges ago, unless any edge in that window had reset low.
    function automatic logic [63:0] model(input int s, input logic [63:0] rv, output bit known);
        int n = hist_rst.size();
        known = 1'b0;
        for (int j = 0; j < s && j < n; j++)
            if (!hist_rst[n-1-j]) begin
                known = 1'b1;
                return rv;
            end
        if (n < s) return '0;
        known = 1'b1;
        return hist_d[n-s];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always begin
        logic [63:0] e;
        bit          k;
        @(posedge clk);
        hist_rst.push_back(reset);
        hist_d.push_back(d);
        #1;
        e = model(1, '0, k);
        if (k) begin
            chk("model_q64", q64, e);
            chk("model_q32", {32'h0, q32}, {32'h0, e[31:0]});
        end
        e = model(3, PRV, k);
        if (k) chk("model_qp", qp, e);
    end

    task automatic step(input logic r, input logic [63:0] v);
        @(negedge clk);
        reset = r;
        d = v;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset hold: d ignored while reset is low.
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 64'(i));
            chk("hold_q64", q64, 64'h0);
            chk("hold_q32", {32'h0, q32}, 64'h0);
        end
        chk("hold_qp", qp, PRV);

        // Normal capture, d changed at negedge.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 64'(i));
            chk("cap_q64", q64, 64'(i));
            chk("cap_q32", {32'h0, q32}, 64'(i));
        end

        // Between-edge stability.
        step(1'b1, 64'h3);
        chk("mid_base", q64, 64'h3);
        @(negedge clk);
        d = 64'h7;
        #1 chk("mid_first", q64, 64'h3);
        #1 d = 64'h9;
        #1 chk("mid_second", q64, 64'h3);
        @(posedge clk);
        #2 chk("mid_edge", q64, 64'h9);

        // Reset mid-stream.
        step(1'b1, 64'h3);
        chk("rms_pre", q64, 64'h3);
        step(1'b0, 64'h4);
        chk("rms_rst", q64, 64'h0);
        chk("rms_rst_qp", qp, PRV);
        step(1'b1, 64'h5);
        chk("rms_rel", q64, 64'h5);

        // Full-width data.
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("fw_ones64", q64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("fw_ones32", {32'h0, q32}, 64'hFFFF_FFFF);
        step(1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
        chk("fw_pat64", q64, 64'hA5A5_5A5A_0F0F_F0F0);
        chk("fw_pat32", {32'h0, q32}, 64'h0F0F_F0F0);

        // Pipelined chain with custom reset value.
        step(1'b0, 64'h77);
        step(1'b0, 64'h88);
        chk("pipe_rst", qp, PRV);
        step(1'b1, 64'h1);
        chk("pipe_e1", qp, PRV);
        step(1'b1, 64'h2);
        chk("pipe_e2", qp, PRV);
        step(1'b1, 64'h3);
        chk("pipe_e3", qp, 64'h1);
        step(1'b1, 64'h0);
        chk("pipe_e4", qp, 64'h2);
        step(1'b1, 64'h0);
        chk("pipe_e5", qp, 64'h3);

        // Random traffic with occasional resets, checked by the model process.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(7) != 0), {$urandom, $urandom});

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
